dice_roll_ctrl: RTL

- Hardware dice-roll controller for the TMBoC user project.
- A roll is started by either of two sources: a pushbutton on an mprj_io input, or a single-cycle request from the on-chip CPU.
- Sequences a spin animation on the displayed face, then draws a uniform result from a free-running LFSR by rejection sampling.
- Reports busy/done status back to firmware.

---
 rtl/dice_pkg.sv | 21 ++
 rtl/dice_roll_ctrl_btn_debounce.sv | 48 ++++
 rtl/dice_roll_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice-roll controller.
// Holds the FSM state encoding and the LFSR width, taps and default seed.
package dice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPIN,
        ST_DRAW,
        ST_DONE
    } state_t;

    localparam int              LFSR_W            = 16;
    // Taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dice_roll_ctrl_btn_debounce.sv
// Two-flop synchroniser plus debounce counter for a raw pushbutton.
// Emits the debounced level and a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
)(
    input  logic clock,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             w_differ;
    logic             w_flip;

    assign w_differ = r_sync[1] ^ r_level;
    assign w_flip   = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            // Any sample matching the current level restarts the stability window.
            if (!w_differ || w_flip)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (w_flip)
                r_level <= ~r_level;
            r_press <= w_flip && !r_level;
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice-roll controller: button/CPU start, spin animation, then an LFSR draw
// by rejection sampling. Reports busy, a result pulse and a completed-roll count.
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int               SIDES           = 6,
    parameter int               DEBOUNCE_CYCLES = 1000,
    parameter int               ANIM_DIV        = 250,
    parameter int               ROLL_STEPS      = 12,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT    = LFSR_SEED_DEFAULT
)(
    input  logic              clock,
    input  logic              rst_n,
    input  logic              roll_btn,
    input  logic              roll_req,
    input  logic              seed_we,
    input  logic [LFSR_W-1:0] seed_data,
    output logic [3:0]        face,
    output logic              busy,
    output logic              result_valid,
    output logic [7:0]        roll_count
);

    localparam int                DIV_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int                STEP_W    = (ROLL_STEPS > 1) ? $clog2(ROLL_STEPS) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(ANIM_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ROLL_STEPS - 1);
    localparam logic [3:0]        FACE_MAX  = 4'(SIDES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [DIV_W-1:0]    r_div;
    logic [STEP_W-1:0]   r_step;
    logic [3:0]          r_face;
    logic [7:0]          r_cnt;

    logic                w_btn_level;
    logic                w_press;
    logic                w_start;
    logic                w_div_tc;
    logic [3:0]          w_sample;
    logic                w_accept;
    logic                w_busy;
    logic                w_valid;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clock   (clock),
        .rst_n   (rst_n),
        .i_btn   (roll_btn),
        .o_level (w_btn_level),
        .o_press (w_press)
    );

    // A press is only trusted while the debounced level agrees with it.
    assign w_start  = (w_press && w_btn_level) || roll_req;
    assign w_div_tc = (r_div == DIV_LAST);
    assign w_sample = r_lfsr[3:0];
    assign w_accept = (w_sample < FACE_MAX);

    // The LFSR free-runs in every state so the draw depends on roll timing.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            r_lfsr <= SEED_DEFAULT;
        else if (seed_we)
            r_lfsr <= (seed_data == '0) ? SEED_DEFAULT : seed_data;
        else
            r_lfsr <= lfsr_next(r_lfsr);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start)
                    w_state_nxt = ST_SPIN;
            end
            ST_SPIN: begin
                w_busy = 1'b1;
                if (w_div_tc && (r_step == STEP_LAST))
                    w_state_nxt = ST_DRAW;
            end
            ST_DRAW: begin
                w_busy = 1'b1;
                if (w_accept)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_valid     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_step <= '0;
            r_face <= 4'd1;
            r_cnt  <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_div  <= '0;
                        r_step <= '0;
                    end
                end
                ST_SPIN: begin
                    if (w_div_tc) begin
                        r_div  <= '0;
                        r_step <= r_step + 1'b1;
                        r_face <= (r_face == FACE_MAX) ? 4'd1 : r_face + 4'd1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_DRAW: begin
                    // Count and face land together so both are final during DONE.
                    if (w_accept) begin
                        r_face <= w_sample + 4'd1;
                        r_cnt  <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign face         = r_face;
    assign busy         = w_busy;
    assign result_valid = w_valid;
    assign roll_count   = r_cnt;

endmodule
